// File: rtl/umq_match_cam_pkg.sv
// Shared constants for the unexpected-message-queue match store:
// FSM state codes, find-mode encoding and small mode decode helpers.
package umq_match_cam_pkg;

   // Find sequencer states: accept -> resolve key -> RAM read -> respond
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOOKUP = 2'd1;
   localparam logic [1:0] ST_READ   = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Find mode is simply {any_src, any_tag}
   localparam logic [1:0] MODE_EXACT    = 2'b00;
   localparam logic [1:0] MODE_ANY_TAG  = 2'b01;
   localparam logic [1:0] MODE_ANY_SRC  = 2'b10;
   localparam logic [1:0] MODE_ANY_BOTH = 2'b11;

   // True when the source rank is a wildcard
   function automatic logic mode_src_wild(input logic [1:0] mode);
      return (mode == MODE_ANY_SRC) || (mode == MODE_ANY_BOTH);
   endfunction

   // True when the tag is a wildcard
   function automatic logic mode_tag_wild(input logic [1:0] mode);
      return (mode == MODE_ANY_TAG) || (mode == MODE_ANY_BOTH);
   endfunction

endpackage

// File: rtl/umq_match_cam_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any bit is set
// and the index of the lowest set bit (0 when none is set).
module umq_match_cam_prio_enc #(
   parameter  int N     = 16,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     vec,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   // Scan from the top down so the lowest set bit is the final assignment
   always_comb begin
      any = |vec;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/umq_match_cam.sv
// Unexpected-message-queue match store. Messages are kept in a direct-mapped
// (rank,tag) store: a valid bitmap in flops plus a payload RAM. A find resolves
// an exact or wildcard key against the bitmap (lowest index wins), reads the
// payload, responds exactly three cycles after acceptance and retires a hit.
module umq_match_cam
   import umq_match_cam_pkg::*;
#(
   parameter  int RANK_BITS = 4,
   parameter  int TAG_BITS  = 4,
   parameter  int PAYLOAD_W = 32,
   localparam int CNT_W     = RANK_BITS + TAG_BITS + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ins_valid,
   output logic                 ins_ready,
   input  logic [RANK_BITS-1:0] ins_rank,
   input  logic [TAG_BITS-1:0]  ins_tag,
   input  logic [PAYLOAD_W-1:0] ins_payload,
   output logic                 ins_dup,
   input  logic                 find_valid,
   output logic                 find_ready,
   input  logic [RANK_BITS-1:0] find_rank,
   input  logic [TAG_BITS-1:0]  find_tag,
   input  logic                 find_any_src,
   input  logic                 find_any_tag,
   output logic                 resp_valid,
   output logic                 resp_found,
   output logic [RANK_BITS-1:0] resp_rank,
   output logic [TAG_BITS-1:0]  resp_tag,
   output logic [PAYLOAD_W-1:0] resp_payload,
   output logic [CNT_W-1:0]     occupancy,
   output logic                 q_empty
);

   localparam int NUM_RANKS   = 2 ** RANK_BITS;
   localparam int NUM_TAGS    = 2 ** TAG_BITS;
   localparam int NUM_ENTRIES = NUM_RANKS * NUM_TAGS;

   logic [1:0]                          state_reg;
   logic [1:0]                          mode_reg;
   logic [RANK_BITS-1:0]                key_rank_reg;
   logic [TAG_BITS-1:0]                 key_tag_reg;
   logic                                hit_reg;
   logic [RANK_BITS-1:0]                match_rank_reg;
   logic [TAG_BITS-1:0]                 match_tag_reg;
   logic [PAYLOAD_W-1:0]                rd_data_reg;
   logic [CNT_W-1:0]                    occ_reg;
   logic                                ins_dup_reg;
   logic [NUM_RANKS-1:0][NUM_TAGS-1:0]  valid_reg;
   logic [PAYLOAD_W-1:0]                mem [NUM_ENTRIES];

   logic                 find_fire, ins_fire, ins_write, clr_fire;
   logic                 src_wild, tag_wild;
   logic [NUM_RANKS-1:0] rank_vec;
   logic                 rank_any;
   logic [RANK_BITS-1:0] enc_rank_idx, sel_rank;
   logic [NUM_TAGS-1:0]  tag_vec;
   logic                 tag_any;
   logic [TAG_BITS-1:0]  enc_tag_idx, sel_tag;
   logic                 lookup_hit;

   assign find_fire = find_valid && (state_reg == ST_IDLE);
   assign clr_fire  = (state_reg == ST_RESP) && hit_reg;
   // The write port is busy clearing the retired entry during a hit response
   assign ins_ready = !clr_fire;
   assign ins_fire  = ins_valid && ins_ready;
   assign ins_write = ins_fire && !valid_reg[ins_rank][ins_tag];

   assign src_wild = mode_src_wild(mode_reg);
   assign tag_wild = mode_tag_wild(mode_reg);

   // Per-rank candidate bit: whole row for ANY_BOTH, else the requested tag column
   genvar gi;
   generate
      for (gi = 0; gi < NUM_RANKS; gi++) begin : g_rank_vec
         assign rank_vec[gi] = tag_wild ? (|valid_reg[gi]) : valid_reg[gi][key_tag_reg];
      end
   endgenerate

   umq_match_cam_prio_enc #(.N(NUM_RANKS)) u_rank_enc (
      .vec (rank_vec),
      .any (rank_any),
      .idx (enc_rank_idx)
   );

   assign sel_rank = src_wild ? enc_rank_idx : key_rank_reg;
   assign tag_vec  = valid_reg[sel_rank];

   umq_match_cam_prio_enc #(.N(NUM_TAGS)) u_tag_enc (
      .vec (tag_vec),
      .any (tag_any),
      .idx (enc_tag_idx)
   );

   assign sel_tag    = tag_wild ? enc_tag_idx : key_tag_reg;
   assign lookup_hit = src_wild ? rank_any
                     : (tag_wild ? tag_any : valid_reg[key_rank_reg][key_tag_reg]);

   // Find sequencer: fixed four-state walk so response latency never varies
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE:   if (find_valid) state_reg <= ST_LOOKUP;
            ST_LOOKUP: state_reg <= ST_READ;
            ST_READ:   state_reg <= ST_RESP;
            default:   state_reg <= ST_IDLE;
         endcase
      end
   end

   // Capture the find key at acceptance so the requester may change its inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_reg     <= MODE_EXACT;
         key_rank_reg <= '0;
         key_tag_reg  <= '0;
      end else if (find_fire) begin
         mode_reg     <= {find_any_src, find_any_tag};
         key_rank_reg <= find_rank;
         key_tag_reg  <= find_tag;
      end
   end

   // Register the resolved match during LOOKUP; it addresses the RAM read next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_reg        <= 1'b0;
         match_rank_reg <= '0;
         match_tag_reg  <= '0;
      end else if (state_reg == ST_LOOKUP) begin
         hit_reg        <= lookup_hit;
         match_rank_reg <= sel_rank;
         match_tag_reg  <= sel_tag;
      end
   end

   // Valid bitmap: set by non-duplicate inserts, cleared when a hit retires
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         if (clr_fire)  valid_reg[match_rank_reg][match_tag_reg] <= 1'b0;
         if (ins_write) valid_reg[ins_rank][ins_tag]             <= 1'b1;
      end
   end

   // Occupancy tracks the bitmap population and saturates at both ends
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_reg <= '0;
      end else if (ins_write && (occ_reg != CNT_W'(NUM_ENTRIES))) begin
         occ_reg <= occ_reg + 1'b1;
      end else if (clr_fire && (occ_reg != '0)) begin
         occ_reg <= occ_reg - 1'b1;
      end
   end

   // Duplicate flag pulses the cycle after an insert lands on an occupied slot
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ins_dup_reg <= 1'b0;
      else     ins_dup_reg <= ins_fire && valid_reg[ins_rank][ins_tag];
   end

   // Payload RAM: one write port, one registered read port, contents not reset
   always_ff @(posedge clk) begin
      if (ins_write) mem[{ins_rank, ins_tag}] <= ins_payload;
      if (state_reg == ST_READ) rd_data_reg <= mem[{match_rank_reg, match_tag_reg}];
   end

   assign find_ready   = (state_reg == ST_IDLE);
   assign resp_valid   = (state_reg == ST_RESP);
   assign resp_found   = resp_valid && hit_reg;
   assign resp_rank    = resp_found ? match_rank_reg : '0;
   assign resp_tag     = resp_found ? match_tag_reg  : '0;
   assign resp_payload = resp_found ? rd_data_reg    : '0;
   assign ins_dup      = ins_dup_reg;
   assign occupancy    = occ_reg;
   assign q_empty      = (occ_reg == '0);

endmodule

// File: tb/tb_umq_match_cam.sv
// Bench for umq_match_cam: directed scenarios plus randomized traffic, checked
// against an array model of the (rank,tag) store with lowest-index search.
module tb_umq_match_cam;

   localparam int RB = 4;
   localparam int TB = 4;
   localparam int PW = 32;
   localparam int CW = RB + TB + 1;
   localparam int NR = 16;
   localparam int NT = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          ins_valid, ins_ready, ins_dup;
   logic [RB-1:0] ins_rank;
   logic [TB-1:0] ins_tag;
   logic [PW-1:0] ins_payload;
   logic          find_valid, find_ready, find_any_src, find_any_tag;
   logic [RB-1:0] find_rank;
   logic [TB-1:0] find_tag;
   logic          resp_valid, resp_found;
   logic [RB-1:0] resp_rank;
   logic [TB-1:0] resp_tag;
   logic [PW-1:0] resp_payload;
   logic [CW-1:0] occupancy;
   logic          q_empty;

   always #5 clk = ~clk;

   umq_match_cam #(.RANK_BITS(RB), .TAG_BITS(TB), .PAYLOAD_W(PW)) dut (
      .clk(clk), .rst(rst),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_rank(ins_rank),
      .ins_tag(ins_tag), .ins_payload(ins_payload), .ins_dup(ins_dup),
      .find_valid(find_valid), .find_ready(find_ready), .find_rank(find_rank),
      .find_tag(find_tag), .find_any_src(find_any_src), .find_any_tag(find_any_tag),
      .resp_valid(resp_valid), .resp_found(resp_found), .resp_rank(resp_rank),
      .resp_tag(resp_tag), .resp_payload(resp_payload),
      .occupancy(occupancy), .q_empty(q_empty)
   );

   // Reference model: which (rank,tag) slots hold a message, and its payload
   bit            mv [NR][NT];
   logic [PW-1:0] mp [NR][NT];
   int            n_checks = 0;
   int            n_fail   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_count();
      int c = 0;
      for (int r = 0; r < NR; r++)
         for (int t = 0; t < NT; t++)
            if (mv[r][t]) c++;
      return c;
   endfunction

   function automatic void model_clear();
      for (int r = 0; r < NR; r++)
         for (int t = 0; t < NT; t++)
            mv[r][t] = 1'b0;
   endfunction

   // Lowest rank first, then lowest tag, among slots the key admits
   function automatic void model_find(input int r, input int t, input bit as, input bit at,
                                      output bit f, output int fr, output int ft);
      f = 1'b0; fr = 0; ft = 0;
      for (int rr = 0; rr < NR; rr++)
         for (int tt = 0; tt < NT; tt++)
            if (!f && mv[rr][tt] && (as || rr == r) && (at || tt == t)) begin
               f = 1'b1; fr = rr; ft = tt;
            end
   endfunction

   task automatic do_insert(input int r, input int t, input logic [PW-1:0] p, input string nm);
      bit dup;
      dup = mv[r][t];
      ins_valid = 1'b1; ins_rank = r[RB-1:0]; ins_tag = t[TB-1:0]; ins_payload = p;
      n_checks++;
      if (ins_ready !== 1'b1) begin n_fail++; $display("FAIL %s ins_ready got %b want 1", nm, ins_ready); end
      tick();
      ins_valid = 1'b0;
      if (!dup) begin mv[r][t] = 1'b1; mp[r][t] = p; end
      $display("insert %s r=%0d t=%0d p=%h dup=%b occ=%0d", nm, r, t, p, ins_dup, occupancy);
      n_checks++;
      if (ins_dup !== dup) begin n_fail++; $display("FAIL %s ins_dup got %b want %b", nm, ins_dup, dup); end
      n_checks++;
      if (occupancy !== CW'(model_count())) begin n_fail++; $display("FAIL %s occupancy got %0d want %0d", nm, occupancy, model_count()); end
      tick();
      n_checks++;
      if (ins_dup !== 1'b0) begin n_fail++; $display("FAIL %s ins_dup_pulse got %b want 0", nm, ins_dup); end
   endtask

   // One find; optional insert in the acceptance cycle (i0) or the cycle after (i1)
   task automatic do_find(input int r, input int t, input bit as, input bit at,
                          input bit i0, input bit i1, input int ir, input int it,
                          input logic [PW-1:0] ip, input string nm);
      bit f, d;
      int fr, ft;
      logic [PW-1:0] ep;
      n_checks++;
      if (find_ready !== 1'b1) begin n_fail++; $display("FAIL %s find_ready got %b want 1", nm, find_ready); end
      find_valid = 1'b1; find_rank = r[RB-1:0]; find_tag = t[TB-1:0];
      find_any_src = as; find_any_tag = at;
      if (i0) begin ins_valid = 1'b1; ins_rank = ir[RB-1:0]; ins_tag = it[TB-1:0]; ins_payload = ip; end
      tick();
      find_valid = 1'b0; ins_valid = 1'b0;
      find_rank = '0; find_tag = '0; find_any_src = 1'b0; find_any_tag = 1'b0;
      if (i0) begin
         d = mv[ir][it];
         if (!d) begin mv[ir][it] = 1'b1; mp[ir][it] = ip; end
         n_checks++;
         if (ins_dup !== d) begin n_fail++; $display("FAIL %s co_ins_dup got %b want %b", nm, ins_dup, d); end
      end
      model_find(r, t, as, at, f, fr, ft);
      ep = f ? mp[fr][ft] : '0;
      n_checks++;
      if (find_ready !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL %s t1 find_ready/resp_valid got %b/%b want 0/0", nm, find_ready, resp_valid); end
      if (i1) begin ins_valid = 1'b1; ins_rank = ir[RB-1:0]; ins_tag = it[TB-1:0]; ins_payload = ip; end
      tick();
      ins_valid = 1'b0;
      if (i1) begin
         d = mv[ir][it];
         if (!d) begin mv[ir][it] = 1'b1; mp[ir][it] = ip; end
         n_checks++;
         if (ins_dup !== d) begin n_fail++; $display("FAIL %s late_ins_dup got %b want %b", nm, ins_dup, d); end
      end
      n_checks++;
      if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL %s t2 resp_valid got %b want 0", nm, resp_valid); end
      tick();
      n_checks++;
      if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL %s t3 resp_valid got %b want 1", nm, resp_valid); end
      $display("find %s key=(%0d,%0d) any_src=%b any_tag=%b -> found=%b r=%0d t=%0d p=%h",
               nm, r, t, as, at, resp_found, resp_rank, resp_tag, resp_payload);
      n_checks++;
      if (resp_found !== f || resp_rank !== RB'(fr) || resp_tag !== TB'(ft) || resp_payload !== ep)
         begin n_fail++; $display("FAIL %s resp got f=%b r=%0d t=%0d p=%h want f=%b r=%0d t=%0d p=%h",
                                  nm, resp_found, resp_rank, resp_tag, resp_payload, f, fr, ft, ep); end
      n_checks++;
      if (ins_ready !== !f) begin n_fail++; $display("FAIL %s resp ins_ready got %b want %b", nm, ins_ready, !f); end
      if (f) mv[fr][ft] = 1'b0;
      tick();
      n_checks++;
      if (resp_valid !== 1'b0 || find_ready !== 1'b1) begin n_fail++; $display("FAIL %s after resp_valid/find_ready got %b/%b want 0/1", nm, resp_valid, find_ready); end
      n_checks++;
      if (occupancy !== CW'(model_count()) || q_empty !== (model_count() == 0))
         begin n_fail++; $display("FAIL %s occ/q_empty got %0d/%b want %0d/%b", nm, occupancy, q_empty, model_count(), model_count() == 0); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ins_valid = 1'b0; ins_rank = '0; ins_tag = '0; ins_payload = '0;
      find_valid = 1'b0; find_rank = '0; find_tag = '0; find_any_src = 1'b0; find_any_tag = 1'b0;
      model_clear();
      tick(); tick();
      rst = 1'b0;
      tick();
      $display("reset done occ=%0d find_ready=%b ins_ready=%b", occupancy, find_ready, ins_ready);
      n_checks++;
      if (occupancy !== '0 || q_empty !== 1'b1) begin n_fail++; $display("FAIL reset occ/q_empty got %0d/%b want 0/1", occupancy, q_empty); end
      n_checks++;
      if (find_ready !== 1'b1 || ins_ready !== 1'b1) begin n_fail++; $display("FAIL reset ready got %b/%b want 1/1", find_ready, ins_ready); end
      n_checks++;
      if (resp_valid !== 1'b0 || resp_found !== 1'b0 || resp_payload !== '0 || ins_dup !== 1'b0)
         begin n_fail++; $display("FAIL reset outputs got rv=%b rf=%b p=%h dup=%b want 0", resp_valid, resp_found, resp_payload, ins_dup); end
   endtask

   task automatic test_exact();
      do_insert(3, 5, 32'hDEADBEEF, "exact_ins");
      do_find(3, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0, "exact_find");
   endtask

   task automatic test_empty_miss();
      do_find(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, '0, "empty_any_any");
   endtask

   task automatic test_any_src();
      do_insert(7, 2, 32'h0000_0702, "anysrc_ins7");
      do_insert(2, 2, 32'h0000_0202, "anysrc_ins2");
      do_insert(9, 2, 32'h0000_0902, "anysrc_ins9");
      for (int k = 0; k < 4; k++)
         do_find($urandom_range(0, NR - 1), 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0, "anysrc_find");
   endtask

   task automatic test_dup();
      do_insert(4, 1, 32'hAAAA_0001, "dup_first");
      do_insert(4, 1, 32'hBBBB_0002, "dup_second");
      do_find(4, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0, "dup_find");
   endtask

   task automatic test_visibility();
      do_find(6, 6, 1'b0, 1'b0, 1'b1, 1'b0, 6, 6, 32'h0606_0001, "vis_same_cycle");
      do_find(6, 6, 1'b0, 1'b0, 1'b0, 1'b1, 6, 6, 32'h0606_0002, "vis_late_ins");
      do_find(6, 6, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0, "vis_cleanup");
   endtask

   task automatic test_reset_mid();
      do_insert(1, 1, 32'h1111_1111, "rstmid_ins_a");
      do_insert(2, 3, 32'h2323_2323, "rstmid_ins_b");
      find_valid = 1'b1; find_any_src = 1'b1; find_any_tag = 1'b1;
      tick();
      find_valid = 1'b0; find_any_src = 1'b0; find_any_tag = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      model_clear();
      $display("reset asserted in READ occ=%0d find_ready=%b", occupancy, find_ready);
      n_checks++;
      if (occupancy !== '0 || find_ready !== 1'b1 || resp_valid !== 1'b0)
         begin n_fail++; $display("FAIL rstmid got occ=%0d fr=%b rv=%b want 0/1/0", occupancy, find_ready, resp_valid); end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_noresp got %b want 0", resp_valid); end
      end
      do_find(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0, "rstmid_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 2) != 0) begin
            do_insert($urandom_range(0, 7), $urandom_range(0, 3), $urandom, "rand_ins");
         end else begin
            bit i0, i1;
            i0 = ($urandom_range(0, 3) == 0);
            i1 = !i0 && ($urandom_range(0, 3) == 0);
            do_find($urandom_range(0, 7), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i0, i1,
                    $urandom_range(0, 7), $urandom_range(0, 3), $urandom, "rand_find");
         end
      end
   endtask

   task automatic test_back_to_back();
      do_insert(0, 9, 32'h0909_0909, "b2b_ins_a");
      do_insert(15, 0, 32'hF0F0_F0F0, "b2b_ins_b");
      do_find(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, '0, "b2b_f1");
      do_find(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, '0, "b2b_f2");
      for (int k = 0; k < 40; k++)
         do_find(0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, '0, "b2b_drain");
   endtask

   initial begin
      test_reset();
      test_exact();
      test_empty_miss();
      test_any_src();
      test_dup();
      test_visibility();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
